// File: rtl/morse_encoder.sv
// morse_encoder: ASCII to Morse keying envelope; optional tone generator enabled by TONE_EN
module morse_encoder #(
  parameter int UNIT_CYCLES = 6000000,
  parameter int TONE_HALF_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       piezo_out,
  output logic       busy,
  output logic       err,
  output logic [3:0] led
);
  localparam int W = $clog2(UNIT_CYCLES);
  typedef enum logic [2:0] {IDLE, MARK, SYMGAP, CHARGAP, WORD} state_t;
  state_t state;
  logic [W-1:0] cnt;
  logic [1:0] units;
  logic [2:0] idx;
  logic [7:0] char_reg;
  logic dash_led, word_led;
  logic [7:0] in_code, cur_code;
  logic tick, cur_dash;
  function automatic logic [7:0] lookup(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
    case (u)
      "A": lookup = 8'b010_00001;
      "B": lookup = 8'b100_01000;
      "C": lookup = 8'b100_01010;
      "D": lookup = 8'b011_00100;
      "E": lookup = 8'b001_00000;
      "F": lookup = 8'b100_00010;
      "G": lookup = 8'b011_00110;
      "H": lookup = 8'b100_00000;
      "I": lookup = 8'b010_00000;
      "J": lookup = 8'b100_00111;
      "K": lookup = 8'b011_00101;
      "L": lookup = 8'b100_00100;
      "M": lookup = 8'b010_00011;
      "N": lookup = 8'b010_00010;
      "O": lookup = 8'b011_00111;
      "P": lookup = 8'b100_00110;
      "Q": lookup = 8'b100_01101;
      "R": lookup = 8'b011_00010;
      "S": lookup = 8'b011_00000;
      "T": lookup = 8'b001_00001;
      "U": lookup = 8'b011_00001;
      "V": lookup = 8'b100_00001;
      "W": lookup = 8'b011_00011;
      "X": lookup = 8'b100_01001;
      "Y": lookup = 8'b100_01011;
      "Z": lookup = 8'b100_01100;
      "0": lookup = 8'b101_11111;
      "1": lookup = 8'b101_01111;
      "2": lookup = 8'b101_00111;
      "3": lookup = 8'b101_00011;
      "4": lookup = 8'b101_00001;
      "5": lookup = 8'b101_00000;
      "6": lookup = 8'b101_10000;
      "7": lookup = 8'b101_11000;
      "8": lookup = 8'b101_11100;
      "9": lookup = 8'b101_11110;
      default: lookup = 8'b000_00000;
    endcase
  endfunction
  assign in_code = lookup(char_data);
  assign cur_code = lookup(char_reg);
  assign cur_dash = cur_code[idx];
  assign tick = cnt == W'(UNIT_CYCLES - 1);
  assign led = {word_led, dash_led, busy, key_out};
  // Sequencer: pattern is right-aligned, the current symbol is bit idx of the latched code
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      units <= '0;
      idx <= '0;
      char_reg <= '0;
      key_out <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      char_ready <= 1'b1;
      dash_led <= 1'b0;
      word_led <= 1'b0;
    end else begin
      err <= 1'b0;
      cnt <= tick ? '0 : cnt + 1'b1;
      units <= units + {1'b0, tick};
      case (state)
        IDLE: begin
          cnt <= '0;
          units <= '0;
          if (!char_ready) char_ready <= 1'b1;
          else if (char_valid) begin
            char_ready <= 1'b0;
            char_reg <= char_data;
            if (char_data == 8'h20) begin
              state <= WORD;
              busy <= 1'b1;
              word_led <= 1'b1;
            end else if (in_code[7:5] != 3'd0) begin
              state <= MARK;
              busy <= 1'b1;
              key_out <= 1'b1;
              idx <= in_code[7:5] - 3'd1;
              dash_led <= in_code[in_code[7:5] - 3'd1];
            end else err <= 1'b1;
          end
        end
        MARK: if (tick && units == (cur_dash ? 2'd2 : 2'd0)) begin
          cnt <= '0;
          units <= '0;
          key_out <= 1'b0;
          dash_led <= 1'b0;
          state <= idx == 3'd0 ? CHARGAP : SYMGAP;
          idx <= idx - 3'd1;
        end
        SYMGAP: if (tick && units == 2'd0) begin
          cnt <= '0;
          units <= '0;
          key_out <= 1'b1;
          dash_led <= cur_dash;
          state <= MARK;
        end
        CHARGAP, WORD: if (tick && units == (state == WORD ? 2'd3 : 2'd2)) begin
          state <= IDLE;
          busy <= 1'b0;
          word_led <= 1'b0;
          char_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef TONE_EN
  localparam int TW = $clog2(TONE_HALF_CYCLES + 1);
  logic [TW-1:0] tone_cnt;
  logic phase;
  // Square wave restarted at phase 0 on every mark
  always_ff @(posedge clk) begin
    if (rst || !key_out) begin
      tone_cnt <= '0;
      phase <= 1'b0;
    end else if (tone_cnt == TW'(TONE_HALF_CYCLES - 1)) begin
      tone_cnt <= '0;
      phase <= ~phase;
    end else tone_cnt <= tone_cnt + 1'b1;
  end
  assign piezo_out = phase & key_out;
`else
  assign piezo_out = key_out;
`endif
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: scoreboard bench for morse_encoder with a 4-cycle unit
module tb_morse_encoder;
  localparam int U = 4;
  localparam int TH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] char_data = 8'h00;
  logic char_valid = 1'b0;
  logic char_ready, key_out, piezo_out, busy, err;
  logic [3:0] led;
  typedef struct packed {logic key, busy, dash, word, ready, err, piezo;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;

  morse_encoder #(.UNIT_CYCLES(U), .TONE_HALF_CYCLES(TH)) dut (
    .clk(clk), .rst(rst), .char_data(char_data), .char_valid(char_valid),
    .char_ready(char_ready), .key_out(key_out), .piezo_out(piezo_out),
    .busy(busy), .err(err), .led(led)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout global");
    $fatal(1, "timeout");
  end

  function automatic string code_of(input logic [7:0] c);
    case (c)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  function automatic logic tone(input int i);
`ifdef TONE_EN
    return ((i / TH) % 2) == 1;
`else
    return 1'b1;
`endif
  endfunction

  function automatic exp_t mk(input logic k, b, d, w, r, er, p);
    exp_t x;
    x = {k, b, d, w, r, er, p};
    return x;
  endfunction

  function automatic logic [8:0] obs();
    return {key_out, busy, led, char_ready, err, piezo_out};
  endfunction

  function automatic logic [8:0] expv(input exp_t x);
    return {x.key, x.busy, x.word, x.dash, x.busy, x.key, x.ready, x.err, x.piezo};
  endfunction

  task automatic push_char(input logic [7:0] c);
    logic [7:0] u;
    string s;
    logic d;
    u = (c >= "a" && c <= "z") ? c - 8'h20 : c;
    if (u == " ") repeat (4 * U) q.push_back(mk(0, 1, 0, 1, 0, 0, 0));
    else begin
      s = code_of(u);
      for (int k = 0; k < s.len(); k++) begin
        d = s[k] == "-";
        for (int i = 0; i < (d ? 3 * U : U); i++) q.push_back(mk(1, 1, d, 0, 0, 0, tone(i)));
        repeat ((k == s.len() - 1) ? 3 * U : U) q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
      end
    end
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!char_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (char_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", char_ready);
    end
    char_data = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== expv(mk(0, 0, 0, 0, 1, 0, 0))) begin
      failures++;
      $display("FAIL reset got=%b exp=%b", obs(), expv(mk(0, 0, 0, 0, 1, 0, 0)));
    end
  endtask

  task automatic test_letter_a();
    int n;
    n = 0;
    push_char("A");
    send("A");
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL letter_a cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
    end
  endtask

  task automatic test_case_fold();
    int n;
    n = 0;
    push_char("e");
    send("e");
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL case_fold cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    push_char("0");
    push_char(" ");
    @(negedge clk);
    char_data = "0";
    char_valid = 1'b1;
    @(posedge clk);
    #1 char_data = " ";
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
      if (e.ready && char_valid) begin
        @(posedge clk);
        #1 char_valid = 1'b0;
      end
    end
  endtask

  task automatic test_unsupported();
    int n;
    n = 0;
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    send("#");
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL unsupported cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
    end
  endtask

  task automatic test_reset_abort();
    int n;
    n = 0;
    push_char("A");
    send("A");
    repeat (10) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL abort_pre cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== expv(mk(0, 0, 0, 0, 1, 0, 0))) begin
      failures++;
      $display("FAIL abort_reset got=%b exp=%b", obs(), expv(mk(0, 0, 0, 0, 1, 0, 0)));
    end
    q.delete();
    n = 0;
    push_char("T");
    send("T");
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL abort_t cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
    end
  endtask

  task automatic test_tone();
    int n;
    n = 0;
    push_char("E");
    send("E");
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      checks++;
      if (obs() !== expv(e)) begin
        failures++;
        $display("FAIL tone cyc=%0d got=%b exp=%b", n, obs(), expv(e));
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_letter_a();
    test_case_fold();
    test_back_to_back();
    test_unsupported();
    test_reset_abort();
    test_tone();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
